// File: rtl/ireq_arbiter.sv
// ireq_arbiter
//   Packet-atomic round-robin arbiter sharing the SRIO initiator-request
//   (ireq) AXI4-Stream channel between NUM_REQ request generators. One
//   requester is granted per packet. The grant is held until its tlast beat
//   handshakes. Forwarded packets are counted, and over-length packets set
//   a sticky error.
//
// Ports (all in the log_clk domain)
//   log_clk, log_rst          clock, async active-high reset
//   link_ready_in             SRIO link up; gates new grants only
//   req_t*_in / req_tready_o  per-requester streams, flattened by index
//   ireq_t*_o / ireq_tready_in  stream towards the SRIO core
//   grant_o                   one-hot current grant, zero when idle
//   busy_o                    a packet is granted
//   pkt_cnt_o                 packets forwarded, wraps at 2^16
//   err_o                     sticky over-length flag
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant; arbitrate when the link is ready and a request is valid
// XFER  | requester gidx_q owns ireq until its tlast beat handshakes
module ireq_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BEATS = 33
) (
  input  logic                    log_clk,
  input  logic                    log_rst,
  input  logic                    link_ready_in,
  input  logic [NUM_REQ-1:0]      req_tvalid_in,
  output logic [NUM_REQ-1:0]      req_tready_o,
  input  logic [NUM_REQ-1:0]      req_tlast_in,
  input  logic [64*NUM_REQ-1:0]   req_tdata_in,
  input  logic [8*NUM_REQ-1:0]    req_tkeep_in,
  input  logic [32*NUM_REQ-1:0]   req_tuser_in,
  output logic                    ireq_tvalid_o,
  input  logic                    ireq_tready_in,
  output logic                    ireq_tlast_o,
  output logic [63:0]             ireq_tdata_o,
  output logic [7:0]              ireq_tkeep_o,
  output logic [31:0]             ireq_tuser_o,
  output logic [NUM_REQ-1:0]      grant_o,
  output logic                    busy_o,
  output logic [15:0]             pkt_cnt_o,
  output logic                    err_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   gidx_q;
  logic [BW-1:0]   beat_q;

  logic [63:0]     data_a [NUM_REQ];
  logic [7:0]      keep_a [NUM_REQ];
  logic [31:0]     user_a [NUM_REQ];

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic            xfer;
  logic            hs;

  // Unflatten the requester buses so the output mux is a plain array index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_a[i] = req_tdata_in[64*i +: 64];
      keep_a[i] = req_tkeep_in[8*i +: 8];
      user_a[i] = req_tuser_in[32*i +: 32];
    end
  end

  // Round-robin search: the first valid requester after the last winner.
  always_comb begin
    logic [IW-1:0] idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_q) + k) % NUM_REQ);
      if (!win_vld && req_tvalid_in[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  assign xfer = (state == XFER);

  // The datapath is a pure mux of the granted requester. A bubble or
  // backpressure therefore shows exactly what the requester drives.
  always_comb begin
    ireq_tvalid_o = 1'b0;
    ireq_tlast_o  = 1'b0;
    ireq_tdata_o  = '0;
    ireq_tkeep_o  = '0;
    ireq_tuser_o  = '0;
    req_tready_o  = '0;
    if (xfer) begin
      ireq_tvalid_o = req_tvalid_in[gidx_q];
      ireq_tlast_o  = req_tlast_in[gidx_q];
      ireq_tdata_o  = data_a[gidx_q];
      ireq_tkeep_o  = keep_a[gidx_q];
      ireq_tuser_o  = user_a[gidx_q];
      req_tready_o  = NUM_REQ'(ireq_tready_in) << gidx_q;
    end
  end

  assign hs = ireq_tvalid_o & ireq_tready_in;

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      state     <= IDLE;
      last_q    <= IW'(NUM_REQ - 1);
      gidx_q    <= '0;
      beat_q    <= '0;
      grant_o   <= '0;
      busy_o    <= 1'b0;
      pkt_cnt_o <= '0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (link_ready_in && win_vld) begin
            state   <= XFER;
            gidx_q  <= win_idx;
            grant_o <= NUM_REQ'(1) << win_idx;
            busy_o  <= 1'b1;
            beat_q  <= '0;
          end
        end
        XFER: begin
          if (hs) begin
            if (ireq_tlast_o) begin
              state     <= IDLE;
              last_q    <= gidx_q;
              grant_o   <= '0;
              busy_o    <= 1'b0;
              pkt_cnt_o <= pkt_cnt_o + 16'd1;
              beat_q    <= '0;
            end else begin
              if (beat_q != BW'(MAX_BEATS))
                beat_q <= beat_q + BW'(1);
              // The limit is reached without tlast. Flag it and let the
              // packet run on, so the requester and the core stay in step.
              if (beat_q == BW'(MAX_BEATS - 1))
                err_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ireq_arbiter.sv
module tb_ireq_arbiter;
  localparam int N  = 2;
  localparam int MB = 4;

  logic            log_clk = 1'b0;
  logic            log_rst = 1'b1;
  logic            link_ready_in;
  logic [N-1:0]    req_tvalid_in, req_tready_o, req_tlast_in;
  logic [64*N-1:0] req_tdata_in;
  logic [8*N-1:0]  req_tkeep_in;
  logic [32*N-1:0] req_tuser_in;
  logic            ireq_tvalid_o, ireq_tready_in, ireq_tlast_o;
  logic [63:0]     ireq_tdata_o;
  logic [7:0]      ireq_tkeep_o;
  logic [31:0]     ireq_tuser_o;
  logic [N-1:0]    grant_o;
  logic            busy_o, err_o;
  logic [15:0]     pkt_cnt_o;

  ireq_arbiter #(.NUM_REQ(N), .MAX_BEATS(MB)) dut (
    .log_clk(log_clk), .log_rst(log_rst), .link_ready_in(link_ready_in),
    .req_tvalid_in(req_tvalid_in), .req_tready_o(req_tready_o),
    .req_tlast_in(req_tlast_in), .req_tdata_in(req_tdata_in),
    .req_tkeep_in(req_tkeep_in), .req_tuser_in(req_tuser_in),
    .ireq_tvalid_o(ireq_tvalid_o), .ireq_tready_in(ireq_tready_in),
    .ireq_tlast_o(ireq_tlast_o), .ireq_tdata_o(ireq_tdata_o),
    .ireq_tkeep_o(ireq_tkeep_o), .ireq_tuser_o(ireq_tuser_o),
    .grant_o(grant_o), .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o), .err_o(err_o)
  );

  always #5 log_clk = ~log_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- requester generators ----------------
  int          pkts_left [N];
  bit          active    [N];
  int          len       [N];
  int          beat      [N];
  int          seq       [N];
  logic [31:0] usr       [N];
  logic [7:0]  kp        [N];
  int          fixed_len = 3;
  int          vld_pct = 100, rdy_pct = 100, link_pct = 100;
  bit          auto_rdy = 0, auto_link = 0;
  logic [N-1:0] acc;

  task automatic advance();
    for (int i = 0; i < N; i++) begin
      if (acc[i] && active[i]) begin
        beat[i]++;
        if (beat[i] == len[i]) active[i] = 0;
      end
      if (!active[i] && pkts_left[i] > 0) begin
        pkts_left[i]--;
        active[i] = 1;
        beat[i]   = 0;
        len[i]    = (fixed_len > 0) ? fixed_len : int'($urandom_range(6, 1));
        seq[i]++;
        usr[i]    = $urandom;
        kp[i]     = 8'($urandom);
      end
    end
  endtask

  task automatic drive_outputs();
    for (int i = 0; i < N; i++) begin
      if (active[i]) begin
        req_tvalid_in[i]          = (int'($urandom_range(99)) < vld_pct);
        req_tlast_in[i]           = (beat[i] == len[i] - 1);
        req_tdata_in[64*i +: 64]  = {8'(i), 8'(len[i]), 16'(seq[i]), 8'(beat[i]),
                                     24'(seq[i] * 31 + beat[i] * 7 + i)};
        req_tkeep_in[8*i +: 8]    = kp[i];
        req_tuser_in[32*i +: 32]  = usr[i];
      end else begin
        req_tvalid_in[i]          = 1'b0;
        req_tlast_in[i]           = 1'b0;
        req_tdata_in[64*i +: 64]  = '0;
        req_tkeep_in[8*i +: 8]    = '0;
        req_tuser_in[32*i +: 32]  = '0;
      end
    end
    if (auto_rdy)  ireq_tready_in = (int'($urandom_range(99)) < rdy_pct);
    if (auto_link) link_ready_in  = (int'($urandom_range(99)) < link_pct);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge log_clk);
      #1;
      advance();
      drive_outputs();
    end
  endtask

  // ---------------- reference model + compare ----------------
  bit   m_busy;
  int   m_g, m_last, m_cnt, m_idx;
  bit   m_err, m_found;
  int   sb_beat, sb_len, sb_seq;
  int   last_seq [N];
  int   out_beats = 0;
  int   grant_log [$];
  bit   hs, m_tlast;
  logic [63:0] d;

  always @(negedge log_clk) begin
    if (log_rst) begin
      m_busy = 0; m_g = 0; m_last = N - 1; m_cnt = 0; m_err = 0; sb_beat = 0;
      acc = '0;
      chk("rst_grant", grant_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_pkt_cnt", pkt_cnt_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_tvalid", ireq_tvalid_o, 0);
      chk("rst_tready", req_tready_o, 0);
    end else begin
      chk("grant", grant_o, m_busy ? 64'(N'(1) << m_g) : 64'd0);
      chk("busy", busy_o, m_busy);
      chk("pkt_cnt", pkt_cnt_o, 64'(m_cnt % 65536));
      chk("err", err_o, m_err);
      if (m_busy) begin
        chk("tvalid", ireq_tvalid_o, req_tvalid_in[m_g]);
        chk("tready", req_tready_o, 64'(N'(ireq_tready_in) << m_g));
        if (req_tvalid_in[m_g]) begin
          chk("tlast", ireq_tlast_o, req_tlast_in[m_g]);
          chk("tdata", ireq_tdata_o, req_tdata_in[64*m_g +: 64]);
          chk("tkeep", ireq_tkeep_o, req_tkeep_in[8*m_g +: 8]);
          chk("tuser", ireq_tuser_o, req_tuser_in[32*m_g +: 32]);
        end
      end else begin
        chk("idle_tvalid", ireq_tvalid_o, 0);
        chk("idle_tready", req_tready_o, 0);
        chk("idle_tdata", ireq_tdata_o, 0);
        chk("idle_tlast", ireq_tlast_o, 0);
      end
      acc = req_tvalid_in & req_tready_o;
      hs  = m_busy && req_tvalid_in[m_g] && ireq_tready_in;
      if (hs) begin
        // Each beat must carry the next beat number of one packet from the
        // granted requester, and tlast must land on its last beat.
        d       = ireq_tdata_o;
        m_tlast = req_tlast_in[m_g];
        out_beats++;
        chk("sb_id", d[63:56], 64'(m_g));
        chk("sb_beat", d[31:24], 64'(sb_beat));
        if (sb_beat == 0) begin
          chk("sb_seq_new", int'(d[47:32]) > last_seq[m_g], 1);
          sb_seq = int'(d[47:32]);
          sb_len = int'(d[55:48]);
        end else begin
          chk("sb_seq_same", d[47:32], 64'(sb_seq));
        end
        chk("sb_tlast", ireq_tlast_o, (sb_beat == sb_len - 1));
        if (m_tlast) begin
          last_seq[m_g] = sb_seq;
          m_busy = 0;
          m_last = m_g;
          m_cnt++;
          sb_beat = 0;
        end else begin
          if (sb_beat + 1 >= MB) m_err = 1;
          sb_beat++;
        end
      end else if (!m_busy && link_ready_in && (|req_tvalid_in)) begin
        m_found = 0;
        for (int k = 1; k <= N; k++) begin
          m_idx = (m_last + k) % N;
          if (!m_found && req_tvalid_in[m_idx]) begin
            m_found = 1;
            m_g = m_idx;
          end
        end
        m_busy  = 1;
        sb_beat = 0;
        grant_log.push_back(m_g);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    #2;
    log_rst = 1'b1;
    #1;
    chk("rst_now_grant", grant_o, 0);
    chk("rst_now_busy", busy_o, 0);
    chk("rst_now_tvalid", ireq_tvalid_o, 0);
    chk("rst_now_tready", req_tready_o, 0);
    chk("rst_now_pkt_cnt", pkt_cnt_o, 0);
    for (int i = 0; i < N; i++) begin
      active[i] = 0;
      pkts_left[i] = 0;
    end
    drive_outputs();
    repeat (2) @(posedge log_clk);
    #3;
    log_rst = 1'b0;
    grant_log.delete();
  endtask

  task automatic wait_cnt(input int target, input int budget, input string nm);
    int c = 0;
    while (int'(pkt_cnt_o) != target && c < budget) begin
      step(1);
      c++;
    end
    chk(nm, pkt_cnt_o, 64'(target));
  endtask

  task automatic wait_beats(input int target, input int budget, input string nm);
    int c = 0;
    while (out_beats < target && c < budget) begin
      step(1);
      c++;
    end
    chk(nm, out_beats >= target, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int b0;

  initial begin
    for (int i = 0; i < N; i++) begin
      pkts_left[i] = 0; active[i] = 0; seq[i] = 0; last_seq[i] = 0;
    end
    link_ready_in = 1'b0;
    ireq_tready_in = 1'b0;
    drive_outputs();
    #1;
    chk("init_grant", grant_o, 0);
    chk("init_busy", busy_o, 0);
    chk("init_pkt_cnt", pkt_cnt_o, 0);
    chk("init_err", err_o, 0);
    repeat (2) @(posedge log_clk);
    #3;
    log_rst = 1'b0;

    // single requester, 3-beat packet
    link_ready_in = 1; ireq_tready_in = 1; vld_pct = 100; fixed_len = 3;
    pkts_left[0] = 1;
    b0 = out_beats;
    step(1);
    step(1);
    chk("t1_grant", grant_o, 2'b01);
    chk("t1_busy", busy_o, 1);
    step(3);
    chk("t1_busy_fall", busy_o, 0);
    chk("t1_pkt_cnt", pkt_cnt_o, 1);
    chk("t1_beats", out_beats - b0, 3);

    // two requesters, continuously valid, 2-beat packets
    do_reset();
    link_ready_in = 1; ireq_tready_in = 1; fixed_len = 2;
    pkts_left[0] = 2; pkts_left[1] = 2;
    wait_cnt(4, 40, "t2_pkt_cnt");
    chk("t2_log_len", grant_log.size() >= 4, 1);
    for (int k = 0; k < 4; k++)
      if (k < grant_log.size()) chk("t2_order", grant_log[k], k % 2);

    // link_ready gating
    do_reset();
    link_ready_in = 0; ireq_tready_in = 1; fixed_len = 4;
    pkts_left[0] = 1; pkts_left[1] = 1;
    step(1);
    step(5);
    chk("t3_no_grant", busy_o, 0);
    #1;
    chk("t3_no_tready", req_tready_o, 0);
    link_ready_in = 1;
    step(1);
    chk("t3_grant", grant_o, 2'b01);
    step(1);
    link_ready_in = 0;
    wait_cnt(1, 20, "t3_finish");
    step(5);
    chk("t3_hold_off", busy_o, 0);
    chk("t3_cnt_hold", pkt_cnt_o, 1);

    // core backpressure for 5 cycles mid-packet
    do_reset();
    link_ready_in = 1; ireq_tready_in = 1; fixed_len = 3;
    pkts_left[0] = 1;
    b0 = out_beats;
    step(3);
    ireq_tready_in = 0;
    #1;
    d = ireq_tdata_o;
    for (int k = 0; k < 5; k++) begin
      step(1);
      #1;
      chk("t4_tready_low", req_tready_o, 0);
      chk("t4_tdata_stable", ireq_tdata_o, d);
      chk("t4_tvalid_held", ireq_tvalid_o, 1);
    end
    ireq_tready_in = 1;
    wait_cnt(1, 20, "t4_pkt_cnt");
    chk("t4_beats", out_beats - b0, 3);

    // over-length packet (6 beats against a limit of 4)
    do_reset();
    link_ready_in = 1; ireq_tready_in = 1; fixed_len = 6;
    pkts_left[0] = 1;
    b0 = out_beats;
    wait_beats(b0 + 3, 20, "t5_three");
    chk("t5_err_before", err_o, 0);
    wait_beats(b0 + 4, 20, "t5_four");
    chk("t5_err_after", err_o, 1);
    wait_cnt(1, 20, "t5_pkt_cnt");
    chk("t5_beats", out_beats - b0, 6);
    fixed_len = 2;
    pkts_left[1] = 1;
    wait_cnt(2, 20, "t5_pkt_cnt2");
    chk("t5_err_sticky", err_o, 1);

    // reset during beat 2
    do_reset();
    link_ready_in = 1; ireq_tready_in = 1; fixed_len = 4;
    pkts_left[0] = 1;
    step(3);
    chk("t6_mid_tvalid", ireq_tvalid_o, 1);
    do_reset();
    fixed_len = 2;
    pkts_left[0] = 1; pkts_left[1] = 1;
    step(2);
    chk("t6_grant", grant_o, 2'b01);
    chk("t6_pkt_cnt", pkt_cnt_o, 0);

    // randomized traffic
    do_reset();
    auto_rdy = 1; auto_link = 1;
    rdy_pct = 75; link_pct = 85; vld_pct = 80; fixed_len = 0;
    pkts_left[0] = 1_000_000; pkts_left[1] = 1_000_000;
    step(3000);
    do_reset();
    pkts_left[0] = 1_000_000; pkts_left[1] = 1_000_000;
    step(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
